// File: rtl/up_mem_loader.sv
// Framed byte-stream program loader that owns the memory write port and holds the CPU off while loading.
// Optional inter-byte timeout inside a frame: define LOADER_TIMEOUT_EN.
module up_mem_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] cpu_address,
    input  logic [7:0] cpu_in,
    input  logic       cpu_we,
    output logic [7:0] mem_address,
    output logic [7:0] mem_in,
    output logic       mem_we,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, DONE} state_t;

    state_t     state_q, state_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       err_q, err_d;
    logic       ld_we_q, ld_we_d;
    logic [7:0] ld_addr_q, ld_addr_d;
    logic [7:0] ld_data_q, ld_data_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] count_q, count_d;
    logic [7:0] sum_q, sum_d;
    logic       accept;
    logic       timeout;

    assign rx_ready = (state_q != DONE);
    assign accept   = rx_valid && rx_ready;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          in_frame;

    assign in_frame = (state_q == ADDR) || (state_q == LEN) ||
                      (state_q == DATA) || (state_q == CSUM);

    always_comb begin
        idle_d = '0;
        if (in_frame && !accept) idle_d = idle_q + 1'b1;
    end

    // Fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout = in_frame && !accept && (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cpu_hold_d = cpu_hold_q;
        err_d      = err_q;
        ld_we_d    = 1'b0;
        ld_addr_d  = ld_addr_q;
        ld_data_d  = ld_data_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        sum_d      = sum_q;
        case (state_q)
            IDLE: if (accept && rx_data == SYNC_BYTE) begin
                state_d    = ADDR;
                cpu_hold_d = 1'b1;
                err_d      = 1'b0;
            end
            ADDR: if (accept) begin
                ptr_d   = rx_data;
                sum_d   = rx_data;
                state_d = LEN;
            end
            LEN: if (accept) begin
                count_d = rx_data;
                sum_d   = sum_q + rx_data;
                state_d = DATA;
            end
            DATA: if (accept) begin
                ld_we_d   = 1'b1;
                ld_addr_d = ptr_q;
                ld_data_d = rx_data;
                ptr_d     = ptr_q + 8'd1;
                sum_d     = sum_q + rx_data;
                count_d   = count_q - 8'd1;
                // A length byte of 0 wraps through 255..1, giving 256 data bytes.
                if (count_q == 8'd1) state_d = CSUM;
            end
            CSUM: if (accept) begin
                if (rx_data != sum_q) err_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                cpu_hold_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            cpu_hold_q <= 1'b0;
            err_q      <= 1'b0;
            ld_we_q    <= 1'b0;
            ld_addr_q  <= 8'd0;
            ld_data_q  <= 8'd0;
            ptr_q      <= 8'd0;
            count_q    <= 8'd0;
            sum_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cpu_hold_q <= cpu_hold_d;
            err_q      <= err_d;
            ld_we_q    <= ld_we_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
        end
    end

    assign cpu_hold    = cpu_hold_q;
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign mem_address = cpu_hold_q ? ld_addr_q : cpu_address;
    assign mem_in      = cpu_hold_q ? ld_data_q : cpu_in;
    assign mem_we      = cpu_hold_q ? ld_we_q   : cpu_we;
endmodule

// File: tb/tb_up_mem_loader.sv
// Bench for up_mem_loader: directed frames plus randomized frames checked against a memory-image model.
module tb_up_mem_loader;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       nRst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] cpu_address, cpu_in;
    logic       cpu_we;
    logic [7:0] mem_address, mem_in;
    logic       mem_we;
    logic       cpu_hold, done, err;

    int checks = 0;
    int errors = 0;
    int gap_max = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int hold_cnt = 0;

    logic [7:0] tb_mem    [256] = '{default: 8'h00};
    logic [7:0] mem_model [256] = '{default: 8'h00};
    logic [7:0] pl [$];

    up_mem_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .nRst(nRst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cpu_address(cpu_address), .cpu_in(cpu_in), .cpu_we(cpu_we),
        .mem_address(mem_address), .mem_in(mem_in), .mem_we(mem_we),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural memory behind the write port.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            tb_mem[mem_address] = mem_in;
            we_cnt++;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (cpu_hold === 1'b1) hold_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mem_diffs();
        int m = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== mem_model[i]) m++;
        return m;
    endfunction

    // Called and returns at a negedge; the byte is taken at the posedge in between.
    task automatic send(input logic [7:0] b);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        rx_valid = 1'b0;
        repeat (g) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready === 1'b1) begin
                @(negedge clk);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("rx_ready_wait", 0, 1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(output int found);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (done === 1'b1) found = 1;
            else @(negedge clk);
        end
    endtask

    // Sends a whole frame with payload pl; model derives checksum and memory image arithmetically.
    task automatic frame(input logic [7:0] addr, input logic bad, input logic noise, input int exp_hold);
        int n, we0, dn0, h0, found;
        logic [7:0] lenb, s, cs, a;
        n    = pl.size();
        lenb = 8'(n);
        s    = 8'((int'(addr) + int'(lenb)) % 256);
        for (int i = 0; i < n; i++) begin
            s = 8'((int'(s) + int'(pl[i])) % 256);
            a = 8'((int'(addr) + i) % 256);
            mem_model[a] = pl[i];
        end
        cs  = bad ? (s ^ 8'h5A) : s;
        we0 = we_cnt;
        dn0 = done_cnt;
        h0  = hold_cnt;
        send(SYNC);
        chk("err_cleared_by_sync", err, 0);
        chk("hold_after_sync", cpu_hold, 1);
        if (noise) begin
            cpu_address = 8'($urandom);
            cpu_in      = 8'($urandom);
            cpu_we      = 1'b1;
        end
        send(addr);
        send(lenb);
        for (int i = 0; i < n; i++) send(pl[i]);
        cpu_we = 1'b0;
        send(cs);
        wait_done(found);
        chk("done_seen", found, 1);
        chk("err_result", err, bad);
        chk("hold_in_done", cpu_hold, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("hold_released", cpu_hold, 0);
        chk("we_pulses", we_cnt - we0, n);
        chk("done_count", done_cnt - dn0, 1);
        if (exp_hold > 0) chk("hold_cycles", hold_cnt - h0, exp_hold);
        chk("mem_image", mem_diffs(), 0);
    endtask

    initial begin
        int found, idle, d0;
        logic [7:0] b;
        nRst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_address = 8'h00; cpu_in = 8'h00; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", rx_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        nRst = 1'b1;
        @(negedge clk);

        // CPU pass-through while idle
        cpu_address = 8'h80; cpu_in = 8'h3C; cpu_we = 1'b1;
        #1;
        chk("pass_addr", mem_address, 8'h80);
        chk("pass_data", mem_in, 8'h3C);
        chk("pass_we", mem_we, 1);
        chk("pass_hold", cpu_hold, 0);
        @(negedge clk);
        cpu_we = 1'b0;
        mem_model[8'h80] = 8'h3C;

        // Good frame, back-to-back: A5 10 02 11 22 45
        pl = '{8'h11, 8'h22};
        frame(8'h10, 1'b0, 1'b0, 6);
        chk("good_mem10", tb_mem[8'h10], 8'h11);
        chk("good_mem11", tb_mem[8'h11], 8'h22);

        // Bad checksum: writes stay, err sticky until the next sync
        pl = '{8'h11, 8'h22};
        frame(8'h10, 1'b1, 1'b0, 6);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        // Length 0 = 256 bytes, address wraps
        pl = {};
        for (int i = 0; i < 256; i++) pl.push_back(8'h01);
        frame(8'hFF, 1'b0, 1'b0, 260);

        // Noise before sync, CPU writes attempted mid-frame
        send(8'h00);
        send(8'h13);
        chk("noise_ignored", cpu_hold, 0);
        pl = '{8'hA5, 8'h5C, 8'hA5};
        frame(8'h40, 1'b0, 1'b1, 7);

        // Randomized frames with gaps, embedded sync values, CPU noise
        gap_max = 2;
        for (int f = 0; f < 12; f++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send(b);
            pl = {};
            for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                pl.push_back(($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom));
            frame(8'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        gap_max = 0;

        // Reset during DATA: hold drops at once, only the first byte reached memory
        send(SYNC); send(8'h90); send(8'h05); send(8'h77); send(8'h88);
        chk("pre_reset_hold", cpu_hold, 1);
        #2 nRst = 1'b0;
        #1;
        chk("async_hold_drop", cpu_hold, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        mem_model[8'h90] = 8'h77;
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        chk("partial_mem", mem_diffs(), 0);
        pl = '{8'h66};
        frame(8'h20, 1'b0, 1'b0, 5);

        // Idle mid-frame after the length-stage entry
        send(SYNC); send(8'h10);
        d0 = done_cnt;
`ifdef LOADER_TIMEOUT_EN
        idle = 0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (done === 1'b1) found = 1;
            else begin @(negedge clk); idle++; end
        end
        chk("timeout_done", found, 1);
        chk("timeout_cycles", idle, 16);
        chk("timeout_err", err, 1);
        @(negedge clk);
        chk("timeout_hold", cpu_hold, 0);
        chk("timeout_done_cnt", done_cnt - d0, 1);
`else
        idle = 0;
        repeat (40) begin @(negedge clk); idle++; end
        chk("no_timeout_done", done_cnt - d0, 0);
        chk("no_timeout_hold", cpu_hold, 1);
        send(8'h01); send(8'h5A); send(8'h6B);
        wait_done(found);
        chk("resume_done", found, 1);
        chk("resume_err", err, 0);
        mem_model[8'h10] = 8'h5A;
        @(negedge clk);
        chk("resume_mem", mem_diffs(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
